// File: rtl/gr_cordic_iter.sv
// Iterative CORDIC Givens-rotation engine: STAGE_ITERS micro-rotations per clock,
// vectoring (self-generated directions) or rotation (neighbour directions), gain-compensated output.
module gr_cordic_iter #(
  parameter int DATA_W      = 13,
  parameter int ITER        = 12,
  parameter int STAGE_ITERS = 4,
  parameter int K_VAL       = 155,
  parameter int K_FRAC      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mode,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] y_in,
  input  logic [ITER-1:0]   dir_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] x_out,
  output logic [DATA_W-1:0] y_out,
  output logic [ITER-1:0]   dir_out,
  output logic              busy
);

  localparam int PASSES = ITER / STAGE_ITERS;
  localparam int IW     = DATA_W + 2;
  localparam int CW     = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int PW     = IW + 32;

  localparam logic signed [PW-1:0] SAT_MAX = (PW'(1) <<< (DATA_W - 1)) - PW'(1);
  localparam logic signed [PW-1:0] SAT_MIN = -(PW'(1) <<< (DATA_W - 1));

  typedef enum logic [1:0] {IDLE, RUN, SCALE, DONE} state_t;

  state_t                state_q, state_d;
  logic signed [IW-1:0]  x_q, x_d, y_q, y_d;
  logic                  mode_q, mode_d;
  logic [ITER-1:0]       dir_q, dir_d;
  logic [CW-1:0]         pass_q, pass_d;
  logic [DATA_W-1:0]     x_out_q, x_out_d, y_out_q, y_out_d;
  logic [ITER-1:0]       dir_out_q, dir_out_d;
  logic                  out_valid_q, out_valid_d;

  logic signed [IW-1:0]  rot_x, rot_y;
  logic [ITER-1:0]       rot_dir;

  // Gain compensation at full precision, floor shift, then clamp to the output range.
  function automatic logic [DATA_W-1:0] scale_sat(input logic signed [IW-1:0] v);
    logic signed [PW-1:0] p;
    p = PW'(v) * PW'(K_VAL);
    p = p >>> K_FRAC;
    if (p > SAT_MAX)      return DATA_W'(SAT_MAX);
    else if (p < SAT_MIN) return DATA_W'(SAT_MIN);
    else                  return DATA_W'(p);
  endfunction

  // One pass of STAGE_ITERS chained micro-rotations.
  always_comb begin : rotate
    logic signed [IW-1:0]   xt, yt, xs, ys;
    logic [STAGE_ITERS-1:0] pass_dir, gen;
    int                     base;
    base     = int'(pass_q) * STAGE_ITERS;
    pass_dir = STAGE_ITERS'(dir_q >> base);
    gen      = '0;
    xt       = x_q;
    yt       = y_q;
    xs       = '0;
    ys       = '0;
    // NOTE: blocking assignments here chain each micro-rotation into the next within one cycle.
    for (int j = 0; j < STAGE_ITERS; j++) begin
      xs     = xt >>> (base + j);
      ys     = yt >>> (base + j);
      gen[j] = yt[IW-1];
      if (mode_q ? yt[IW-1] : pass_dir[j]) begin
        xt = xt - ys;
        yt = yt + xs;
      end else begin
        xt = xt + ys;
        yt = yt - xs;
      end
    end
    rot_x   = xt;
    rot_y   = yt;
    rot_dir = mode_q ? (dir_q | (ITER'(gen) << base)) : dir_q;
  end

  always_comb begin
    in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  end

  always_comb begin
    // NOTE: every _d defaults to its _q so no path through the case infers a latch.
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    mode_d      = mode_q;
    dir_d       = dir_q;
    pass_d      = pass_q;
    x_out_d     = x_out_q;
    y_out_d     = y_out_q;
    dir_out_d   = dir_out_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = IW'($signed(x_in));
          y_d     = IW'($signed(y_in));
          mode_d  = mode;
          dir_d   = mode ? '0 : dir_in;
          pass_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        x_d   = rot_x;
        y_d   = rot_y;
        dir_d = rot_dir;
        if (pass_q == CW'(PASSES - 1)) begin
          pass_d  = '0;
          state_d = SCALE;
        end else begin
          pass_d = pass_q + CW'(1);
        end
      end
      SCALE: begin
        x_out_d     = scale_sat(x_q);
        y_out_d     = scale_sat(y_q);
        dir_out_d   = dir_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (in_valid) begin
            x_d     = IW'($signed(x_in));
            y_d     = IW'($signed(y_in));
            mode_d  = mode;
            dir_d   = mode ? '0 : dir_in;
            pass_d  = '0;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      mode_q      <= 1'b0;
      dir_q       <= '0;
      pass_q      <= '0;
      x_out_q     <= '0;
      y_out_q     <= '0;
      dir_out_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      mode_q      <= mode_d;
      dir_q       <= dir_d;
      pass_q      <= pass_d;
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
      dir_out_q   <= dir_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign dir_out   = dir_out_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_gr_cordic_iter.sv
// Bench for gr_cordic_iter: scoreboard against an integer CORDIC model, table-driven
// vectors, plus reset, backpressure and streaming sequences.
module tb_gr_cordic_iter;

  localparam int DATA_W = 13;
  localparam int ITER   = 12;
  localparam int PASSES = 3;
  localparam int K_VAL  = 155;
  localparam int K_FRAC = 8;
  localparam int LAT    = PASSES + 2;

  logic              clk, rst;
  logic              in_valid, in_ready, mode;
  logic [DATA_W-1:0] x_in, y_in;
  logic [ITER-1:0]   dir_in;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] x_out, y_out;
  logic [ITER-1:0]   dir_out;
  logic              busy;

  gr_cordic_iter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .x_in(x_in), .y_in(y_in), .dir_in(dir_in), .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .dir_out(dir_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int              x;
    int              y;
    logic [ITER-1:0] dir;
  } res_t;

  typedef struct {
    bit              m;
    int              x;
    int              y;
    logic [ITER-1:0] d;
    bit              has_range;
    int              xlo;
    int              xhi;
    int              ymax;
  } vec_t;

  res_t sb[$];
  res_t last;
  int   checks = 0, errors = 0, tick_no = 0;
  int   last_accept_tick = 0, last_retire_tick = 0;
  bit   accepted, retired;

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected in [%0d,%0d]", name, act, lo, hi);
    end
  endtask

  function automatic int sx(input logic [DATA_W-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int sat(input longint v);
    if (v > 4095) return 4095;
    if (v < -4096) return -4096;
    return int'(v);
  endfunction

  function automatic res_t model(input bit m, input int x, input int y, input logic [ITER-1:0] d);
    res_t r;
    int xi = x, yi = y, xn, yn;
    bit di;
    r.dir = '0;
    for (int i = 0; i < ITER; i++) begin
      di = m ? (yi < 0) : d[i];
      r.dir[i] = di;
      if (di) begin xn = xi - (yi >>> i); yn = yi + (xi >>> i); end
      else    begin xn = xi + (yi >>> i); yn = yi - (xi >>> i); end
      xi = xn;
      yi = yn;
    end
    r.x = sat((longint'(xi) * K_VAL) >>> K_FRAC);
    r.y = sat((longint'(yi) * K_VAL) >>> K_FRAC);
    return r;
  endfunction

  // Sample handshakes mid-cycle, then advance one clock to the next falling edge.
  task automatic tick();
    res_t e;
    #1;
    accepted = 1'b0;
    retired  = 1'b0;
    if (rst) begin
      sb.delete();
    end else begin
      if (in_valid && in_ready) begin
        accepted = 1'b1;
        last_accept_tick = tick_no;
        sb.push_back(model(mode, sx(x_in), sx(y_in), dir_in));
      end
      if (out_valid && out_ready) begin
        retired = 1'b1;
        last_retire_tick = tick_no;
        last.x = sx(x_out);
        last.y = sx(y_out);
        last.dir = dir_out;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got output x=%0d with nothing expected", last.x);
        end else begin
          e = sb.pop_front();
          check("sb_x", last.x, e.x);
          check("sb_y", last.y, e.y);
          check("sb_dir", int'(last.dir), int'(e.dir));
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    tick_no++;
  endtask

  task automatic run_one(input bit m, input int x, input int y, input logic [ITER-1:0] d,
                         output res_t got);
    int  acc_tick = -1;
    bit  done = 1'b0;
    mode      = m;
    x_in      = DATA_W'(x);
    y_in      = DATA_W'(y);
    dir_in    = d;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      tick();
      if (accepted) begin done = 1'b1; acc_tick = last_accept_tick; end
    end
    in_valid = 1'b0;
    check("accept_seen", int'(done), 1);
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      tick();
      if (retired) done = 1'b1;
    end
    check("result_seen", int'(done), 1);
    check("latency", last_retire_tick - acc_tick, LAT);
    got = last;
  endtask

  vec_t vt[7];
  res_t got, vec_res;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int hx, hy, hd, saw_valid, acc_cnt, ret_cnt, prev_acc;
    int sx_tab[8], sy_tab[8];
    logic [ITER-1:0] sd_tab[8];

    vt[0] = '{1'b1, 1000,     0, 12'h000, 1'b1,  990, 1000, 4};
    vt[1] = '{1'b1,  600,   800, 12'h000, 1'b1,  990, 1002, 4};
    vt[2] = '{1'b1, 4095,  4095, 12'h000, 1'b1, 4095, 4095, 8};
    vt[3] = '{1'b1, -800,   300, 12'h000, 1'b0,    0,    0, 0};
    vt[4] = '{1'b0, 1000,  -500, 12'hA5C, 1'b0,    0,    0, 0};
    vt[5] = '{1'b0, -4096, -4096, 12'h000, 1'b0,   0,    0, 0};
    vt[6] = '{1'b0, 4095, -4096, 12'hFFF, 1'b0,    0,    0, 0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0;
    x_in = '0; y_in = '0; dir_in = '0;
    @(negedge clk);
    tick();
    tick();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_x_out", sx(x_out), 0);
    check("rst_y_out", sx(y_out), 0);
    check("rst_dir_out", int'(dir_out), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    tick();
    check("rst_in_ready", int'(in_ready), 1);

    for (int v = 0; v < 7; v++) begin
      run_one(vt[v].m, vt[v].x, vt[v].y, vt[v].d, got);
      if (vt[v].has_range) begin
        check_range($sformatf("vec%0d_x_range", v), got.x, vt[v].xlo, vt[v].xhi);
        check_range($sformatf("vec%0d_y_range", v), got.y, -vt[v].ymax, vt[v].ymax);
      end
      if (v == 1) vec_res = got;
    end

    // Replaying the recorded directions in rotation mode must reproduce the vectoring result.
    run_one(1'b0, 600, 800, vec_res.dir, got);
    check("replay_x", got.x, vec_res.x);
    check("replay_y", got.y, vec_res.y);
    check("replay_dir", int'(got.dir), int'(vec_res.dir));

    // Reset during RUN discards the operation.
    mode = 1'b1; x_in = DATA_W'(1000); y_in = '0; dir_in = '0;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    check("midrun_accept", int'(accepted), 1);
    in_valid = 1'b0;
    tick();
    check("midrun_busy_before", int'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrun_out_valid", int'(out_valid), 0);
    check("midrun_x_out", sx(x_out), 0);
    check("midrun_y_out", sx(y_out), 0);
    check("midrun_busy", int'(busy), 0);
    check("midrun_in_ready", int'(in_ready), 1);
    saw_valid = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (out_valid) saw_valid = 1;
    end
    check("midrun_no_output", saw_valid, 0);

    // Backpressure: hold results, ignore new input, then retire and accept on one edge.
    mode = 1'b1; x_in = DATA_W'(700); y_in = DATA_W'(-300); dir_in = '0;
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    check("bp_accept", int'(accepted), 1);
    mode = 1'b0; x_in = DATA_W'(1234); y_in = DATA_W'(-2000); dir_in = 12'h3C5;
    saw_valid = 0;
    for (int k = 0; k < 20 && saw_valid == 0; k++) begin
      tick();
      check("bp_no_accept_run", int'(accepted), 0);
      if (out_valid) saw_valid = 1;
    end
    check("bp_valid_seen", saw_valid, 1);
    hx = sx(x_out); hy = sx(y_out); hd = int'(dir_out);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_x_stable", sx(x_out), hx);
      check("bp_y_stable", sx(y_out), hy);
      check("bp_dir_stable", int'(dir_out), hd);
      check("bp_valid_held", int'(out_valid), 1);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_busy", int'(busy), 1);
    end
    out_ready = 1'b1;
    tick();
    check("bp_retire", int'(retired), 1);
    check("bp_same_edge_accept", int'(accepted), 1);
    in_valid = 1'b0;
    check("bp_valid_falls", int'(out_valid), 0);
    check("bp_busy_after", int'(busy), 1);
    saw_valid = 0;
    for (int k = 0; k < 20 && saw_valid == 0; k++) begin
      tick();
      if (retired) saw_valid = 1;
    end
    check("bp_second_result", saw_valid, 1);

    // Streaming: back-to-back random rotations, accepts every LAT cycles.
    for (int k = 0; k < 8; k++) begin
      sx_tab[k] = int'($urandom_range(8191)) - 4096;
      sy_tab[k] = int'($urandom_range(8191)) - 4096;
      sd_tab[k] = ITER'($urandom);
    end
    acc_cnt = 0; ret_cnt = 0; prev_acc = 0;
    mode = 1'b0; x_in = DATA_W'(sx_tab[0]); y_in = DATA_W'(sy_tab[0]); dir_in = sd_tab[0];
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 80 && ret_cnt < 8; k++) begin
      tick();
      if (retired) ret_cnt++;
      if (accepted) begin
        if (acc_cnt > 0) check("stream_spacing", last_accept_tick - prev_acc, LAT);
        prev_acc = last_accept_tick;
        acc_cnt++;
        if (acc_cnt < 8) begin
          x_in = DATA_W'(sx_tab[acc_cnt]);
          y_in = DATA_W'(sy_tab[acc_cnt]);
          dir_in = sd_tab[acc_cnt];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check("stream_accepts", acc_cnt, 8);
    check("stream_results", ret_cnt, 8);
    check("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
